// File: rtl/cook_station_bank.sv
// Bank of independent board/pot process timers stepped once per frame; all outputs registered.
// Latency: start gives RUN the same edge. done and fire pulse one cycle. No backpressure.
module cook_station_bank #(
    parameter int                      NUM_STATIONS  = 6,
    parameter logic [NUM_STATIONS-1:0] BOARD_MASK    = 6'b000011,
    parameter int                      TICKS_PER_SEC = 60,
    parameter int                      CHOP_TIME     = 5,
    parameter int                      COOK_TIME     = 10,
    parameter int                      BURN_TIME     = 5,
    parameter int                      TW            = 4
) (
    input  logic                             vsync,
    input  logic                             reset,
    input  logic                             freeze,
    input  logic [NUM_STATIONS-1:0]          start,
    input  logic [NUM_STATIONS-1:0]          active,
    input  logic [NUM_STATIONS-1:0]          clear,
    output logic [NUM_STATIONS-1:0][2:0]     station_state,
    output logic [NUM_STATIONS-1:0][TW-1:0]  time_left,
    output logic [NUM_STATIONS-1:0]          done,
    output logic [NUM_STATIONS-1:0]          fire,
    output logic                             any_fire
);

    localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SW-1:0] SUB_MAX = SW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] CHOP_T  = TW'(CHOP_TIME);
    localparam logic [TW-1:0] COOK_T  = TW'(COOK_TIME);
    localparam logic [TW-1:0] BURN_T  = TW'(BURN_TIME);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_HOLD = 3'd2,
        ST_DONE = 3'd3,
        ST_FIRE = 3'd4
    } state_e;

    state_e            state_q [NUM_STATIONS];
    state_e            state_d [NUM_STATIONS];
    logic [TW-1:0]     tl_q    [NUM_STATIONS];
    logic [TW-1:0]     tl_d    [NUM_STATIONS];
    logic [SW-1:0]     sub_q   [NUM_STATIONS];
    logic [SW-1:0]     sub_d   [NUM_STATIONS];
    logic [NUM_STATIONS-1:0] done_q, done_d;
    logic [NUM_STATIONS-1:0] fire_q, fire_d;
    logic [NUM_STATIONS-1:0] cnt_en;
    logic              any_fire_q, any_fire_d;

    always_comb begin
        done_d     = '0;
        fire_d     = '0;
        cnt_en     = '0;
        any_fire_d = 1'b0;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            state_d[i] = state_q[i];
            tl_d[i]    = tl_q[i];
            sub_d[i]   = sub_q[i];
            if (clear[i]) begin
                state_d[i] = ST_IDLE;
                tl_d[i]    = '0;
                sub_d[i]   = '0;
            end else if (start[i] && state_q[i] == ST_IDLE) begin
                state_d[i] = ST_RUN;
                tl_d[i]    = BOARD_MASK[i] ? CHOP_T : COOK_T;
                sub_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: ;
                    ST_RUN: begin
                        if (!freeze) begin
                            if (BOARD_MASK[i] && !active[i]) state_d[i] = ST_HOLD;
                            else                             cnt_en[i]  = 1'b1;
                        end
                    end
                    // Resume counts on the same edge so a pause costs exactly its frames.
                    ST_HOLD: begin
                        if (!freeze && active[i]) begin
                            state_d[i] = ST_RUN;
                            cnt_en[i]  = 1'b1;
                        end
                    end
                    ST_DONE: cnt_en[i] = !BOARD_MASK[i] && !freeze;
                    ST_FIRE: ;
                    default: begin
                        state_d[i] = ST_IDLE;
                        tl_d[i]    = '0;
                        sub_d[i]   = '0;
                    end
                endcase
            end

            if (cnt_en[i]) begin
                if (sub_q[i] == SUB_MAX) begin
                    sub_d[i] = '0;
                    if (tl_q[i] != '0) tl_d[i] = tl_q[i] - TW'(1);
                    if (tl_q[i] == TW'(1)) begin
                        if (state_q[i] == ST_DONE) begin
                            state_d[i] = ST_FIRE;
                            fire_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = ST_DONE;
                            done_d[i]  = 1'b1;
                            if (!BOARD_MASK[i]) tl_d[i] = BURN_T;
                        end
                    end
                end else begin
                    sub_d[i] = sub_q[i] + SW'(1);
                end
            end

            if (state_d[i] == ST_FIRE) any_fire_d = 1'b1;
        end
    end

    always_ff @(posedge vsync) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATIONS; i++) begin
                state_q[i] <= ST_IDLE;
                tl_q[i]    <= '0;
                sub_q[i]   <= '0;
            end
            done_q     <= '0;
            fire_q     <= '0;
            any_fire_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_STATIONS; i++) begin
                state_q[i] <= state_d[i];
                tl_q[i]    <= tl_d[i];
                sub_q[i]   <= sub_d[i];
            end
            done_q     <= done_d;
            fire_q     <= fire_d;
            any_fire_q <= any_fire_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_STATIONS; i++) begin
            station_state[i] = state_q[i];
            time_left[i]     = tl_q[i];
        end
    end

    assign done     = done_q;
    assign fire     = fire_q;
    assign any_fire = any_fire_q;

endmodule

// File: doc/cook_station_bank.md
# cook_station_bank

Parametrised bank of per-station process timers for the kitchen: chopping boards and cooking pots. Replaces the fixed-count countdown instances inside the player action logic. Each channel runs its own state machine with a frame-accurate sub-second prescaler, pause-on-release for boards, and a cooked-to-fire burn phase for pots. Action logic drives start, hold and clear strobes and reads back state, remaining seconds and event pulses.

## Interface
- NUM_STATIONS, 6, number of channels
- BOARD_MASK, 6'b000011, bit i = 1 makes channel i a board; 0 makes it a pot
- TICKS_PER_SEC, 60, frames per displayed second
- CHOP_TIME, 5, board process time in seconds
- COOK_TIME, 10, pot cook time in seconds
- BURN_TIME, 5, seconds a cooked pot survives before fire
- TW, 4, width of time_left; must hold max(CHOP_TIME, COOK_TIME, BURN_TIME)
- vsync, in, 1, the only clock; one edge per frame
- reset, in, 1, synchronous, active-high
- freeze, in, 1, level; high halts all counting (game paused)
- start, in, NUM_STATIONS, per-channel load strobe (item placed / chop begun)
- active, in, NUM_STATIONS, per-channel level; boards count only while high; ignored for pots
- clear, in, NUM_STATIONS, per-channel strobe; returns the channel to IDLE (item removed / fire extinguished)
- station_state, out, NUM_STATIONS x 3, per-channel state code
- time_left, out, NUM_STATIONS x TW, seconds remaining in the current phase
- done, out, NUM_STATIONS, one-cycle pulse on process completion
- fire, out, NUM_STATIONS, one-cycle pulse on entry to FIRE
- any_fire, out, 1, level; OR of all channels in FIRE

## Operation
- State codes: IDLE=0, RUN=1, HOLD=2, DONE=3, FIRE=4. Codes 5-7 unreachable; if present, next state is IDLE.
- Per channel: state register, time_left register (TW bits), sub-second counter of width clog2(TICKS_PER_SEC).
- Counting edge: state is RUN, or state is DONE on a pot, and freeze=0. Sub counter increments. At TICKS_PER_SEC-1 it wraps to 0 and time_left decrements.
- Priority per channel per edge: reset > clear > start > state transition/count.
- IDLE: start loads time_left (CHOP_TIME for a board, COOK_TIME for a pot) and clears sub. Next state is RUN.
- Board RUN: if active=0, go to HOLD with count frozen. Otherwise count.
- Board HOLD: if active=1, go to RUN. Sub and time_left are retained, so partial progress is kept.
- RUN to DONE: on the edge where time_left goes 1 to 0. done pulses in the same registered cycle.
- Board DONE: static. time_left = 0 until clear.
- Pot DONE: on entry, time_left loads BURN_TIME and sub clears. The channel counts down the burn phase. On the edge where time_left goes 1 to 0, it enters FIRE and fire pulses.
- FIRE: terminal. time_left = 0. Only clear or reset leave it.
- start in any state other than IDLE: ignored.
- clear in any state: IDLE, time_left = 0, sub = 0. No done or fire pulse.
- freeze does not block start or clear. It does block board RUN/HOLD transitions; active is re-sampled when freeze drops.
- Channels are fully independent. Simultaneous events on different channels never interact.

## Timing
- Reset value of every output is 0: station_state = IDLE, time_left = 0, done = 0, fire = 0, any_fire = 0.
- All outputs are registered. any_fire is registered from next-state.
- start sampled at edge k gives RUN with time_left = T at edge k.
- With uninterrupted counting, done is high for exactly the cycle after edge k + T*TICKS_PER_SEC.
- Pot fire pulses BURN_TIME*TICKS_PER_SEC edges after done.
- time_left steps down on sub-counter wrap only. It never underflows.
- HOLD and freeze periods extend latency by exactly their length in frames.
- Reset mid-operation: all channels go to IDLE on that edge. In-flight pulses are dropped.

## Test plan
- Board basic (TICKS_PER_SEC=4, CHOP_TIME=5): start[0] pulse, active[0]=1 → time_left 5,4,3,2,1,0 at 4-frame steps; done[0] is a single pulse 20 edges after start; state goes RUN→DONE.
- Board pause: active[0] drops for 7 frames at time_left=3 with sub=2 → state HOLD, values held; on resume, done is delayed by exactly 7 frames.
- Pot burn (COOK_TIME=10, BURN_TIME=5): start[3] with no active → done[3] at 40 edges; time_left reloads to 5; fire[3] pulses at edge 60; any_fire=1 until clear[3], after which state is IDLE and any_fire=0.
- Priority: clear and start in the same cycle while IDLE → stays IDLE. start while RUN → time_left unchanged.
- freeze held for 10 frames mid-cook on two channels → neither time_left nor sub changes; a clear during freeze still forces IDLE.
- reset asserted while channel 2 is in DONE and channel 5 is in FIRE → every output is 0 on the next cycle.
